servo_ramp_ctrl: RTL
====================

Name: servo_ramp_ctrl

Overview:
Command-driven sequencer for one PWM servo channel. It accepts a target position, then slews the PWM pulsewidth toward that target by a fixed step once per PWM frame, so the servo never sees a large jump. It sits between the host/register interface and the PWM generator, and drives that generator's pulsewidth and enable inputs. The PWM generator supplies a one-cycle frame_tick at each period wrap.

Parameters:
RES, 8, width of pulsewidth, target and clamp limits; must match the PWM generator.
STEP_W, 4, width of cmd_step; STEP_W <= RES.
RESET_PW, 128, pulsewidth value loaded at reset (servo centre).
HOLD_FRAMES, 50, frames spent in HOLD before release (used only with HOLD_TIMEOUT_EN).

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-high reset.
frame_tick  in  1  one-cycle pulse per PWM period, from the PWM generator.
min_pw  in  RES  lower clamp limit, sampled on command accept.
max_pw  in  RES  upper clamp limit, sampled on command accept.
cmd_valid  in  1  command request.
cmd_ready  out  1  controller can accept a command.
cmd_target  in  RES  requested pulsewidth.
cmd_step  in  STEP_W  slew per frame; 0 is treated as 1.
abort  in  1  stop the ramp at the current pulsewidth.
pulsewidth  out  RES  registered; drives the PWM generator's pulsewidth input.
pwm_en  out  1  registered; drives the PWM generator's enable input.
busy  out  1  high while in RAMP.
done  out  1  one-cycle pulse when a ramp reaches its target.

Behaviour:
- Reset (async): state=IDLE, pulsewidth=RESET_PW, pwm_en=0, done=0, latched target=RESET_PW, latched step=1.
- States: IDLE, RAMP, HOLD. busy = (state==RAMP). cmd_ready = (state!=RAMP).
- Accept occurs on a cycle with cmd_valid & cmd_ready. On accept:
  - latch target = clamp(cmd_target, min_pw, max_pw); if min_pw > max_pw, target = min_pw.
  - latch step = max(cmd_step, 1), zero-extended to RES bits.
  - set pwm_en=1 and go to RAMP.
- Priority: an accept in a given cycle takes precedence over frame_tick in that cycle. The tick is ignored, and pulsewidth is unchanged until the next tick.
- RAMP, on frame_tick (abort low):
  - diff = |target - pulsewidth|, computed in RES+1 bits with no wrap.
  - if diff <= step: pulsewidth = target, done=1 for that cycle, go to HOLD.
  - else: pulsewidth moves by step toward target. Intermediate values never overshoot or wrap past 0 or 2^RES-1.
- Accept of a target equal to the current pulsewidth: enter RAMP; done pulses on the next frame_tick.
- RAMP with abort=1 (abort takes priority over frame_tick): go to HOLD immediately, keep pulsewidth, no done pulse. abort is ignored outside RAMP.
- HOLD: pulsewidth and pwm_en stay constant; a new accept goes to RAMP starting from the current pulsewidth.
- pwm_en rises on the first accept. It stays high until reset, or until timeout when the optional feature is compiled in.
- Latency: accept -> first pulsewidth change at the first frame_tick strictly after the accept cycle; update is visible the cycle after that tick.
- Reset mid-RAMP: all registers return to reset values at once; no done pulse.

Optional Feature:
HOLD_TIMEOUT_EN
- Defined: a frame counter clears on entry to HOLD and increments on each frame_tick in HOLD. When it reaches HOLD_FRAMES, the controller sets pwm_en=0 and goes to IDLE (servo released); pulsewidth is retained. A new accept re-enables pwm_en. An accept in the same cycle as the timeout wins: the controller goes to RAMP with pwm_en=1.
- Undefined: no counter; HOLD persists indefinitely with pwm_en=1.

Test Plan:
1. Reset, RES=8 -> pulsewidth=128, pwm_en=0, cmd_ready=1, busy=0, done=0.
2. min=10, max=250, accept target=140 step=5, then 3 ticks -> pulsewidth 133, 138, 140; done on third tick; pwm_en=1 from cycle after accept; busy low after.
3. From 140, accept target=255 step=15 with max=200 -> pulsewidth 155, 170, 185, 200, then done; never exceeds 200.
4. From 200, accept target=197 step=0 -> pulsewidth 199, 198, 197; done on third tick.
5. frame_tick coincident with accept (pulsewidth=197, target=100, step=10) -> no change that cycle; next tick gives 187. Assert abort after 187 -> HOLD, pulsewidth stays 187, no done.
6. With HOLD_TIMEOUT_EN and HOLD_FRAMES=3: after done, 3 ticks -> pwm_en=0, state IDLE, pulsewidth held. Assert rst mid-RAMP -> immediate 128/pwm_en=0.

Source files
------------

// File: rtl/servo_ramp_ctrl.sv
// Slew-limited pulsewidth sequencer for one PWM servo channel (IDLE/RAMP/HOLD).
// Optional macro HOLD_TIMEOUT_EN releases the servo after HOLD_FRAMES idle frames in HOLD.
module servo_ramp_ctrl #(
    parameter int RES         = 8,
    parameter int STEP_W      = 4,
    parameter int RESET_PW    = 128,
    parameter int HOLD_FRAMES = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic [RES-1:0]    min_pw,
    input  logic [RES-1:0]    max_pw,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [RES-1:0]    cmd_target,
    input  logic [STEP_W-1:0] cmd_step,
    input  logic              abort,
    output logic [RES-1:0]    pulsewidth,
    output logic              pwm_en,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [RES-1:0] target, target_nxt;
    logic [RES-1:0] step, step_nxt;
    logic [RES-1:0] pw_nxt;
    logic           en_nxt;
    logic           done_nxt;
    logic           accept;
    logic           timeout;
    logic [RES-1:0] clamped;
    logic [RES-1:0] step_in;
    logic [RES:0]   diff;

    // Handshake: a command transfers on any cycle where cmd_valid and cmd_ready are both
    // high; cmd_ready is low only while ramping, and cmd_valid may be withdrawn freely.
    assign cmd_ready = (state != RAMP);
    assign busy      = (state == RAMP);
    assign accept    = cmd_valid & cmd_ready;
    assign state_dbg = state;

    always_comb begin
        clamped = cmd_target;
        if ((min_pw > max_pw) || (cmd_target < min_pw))
            clamped = min_pw;
        else if (cmd_target > max_pw)
            clamped = max_pw;
    end

    assign step_in = (cmd_step == '0) ? RES'(1) : RES'(cmd_step);

    // Distance carried in RES+1 bits so neither direction can wrap.
    assign diff = (target >= pulsewidth) ? ({1'b0, target} - {1'b0, pulsewidth})
                                         : ({1'b0, pulsewidth} - {1'b0, target});

`ifdef HOLD_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_FRAMES) + 1;
    logic [CNT_W-1:0] hold_cnt;

    // The counter sits at zero outside HOLD, so every entry into HOLD starts a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold_cnt <= '0;
        else if (state != HOLD)
            hold_cnt <= '0;
        else if (frame_tick)
            hold_cnt <= hold_cnt + CNT_W'(1);
    end

    assign timeout = (state == HOLD) && frame_tick && (hold_cnt == CNT_W'(HOLD_FRAMES - 1));
`else
    logic [31:0] unused_hold_frames;
    assign unused_hold_frames = 32'(HOLD_FRAMES);
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        step_nxt   = step;
        pw_nxt     = pulsewidth;
        en_nxt     = pwm_en;
        done_nxt   = 1'b0;
        case (state)
            IDLE, HOLD: begin
                if (accept) begin
                    target_nxt = clamped;
                    step_nxt   = step_in;
                    en_nxt     = 1'b1;
                    state_nxt  = RAMP;
                end else if (timeout) begin
                    en_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            RAMP: begin
                if (abort) begin
                    state_nxt = HOLD;
                end else if (frame_tick) begin
                    if (diff <= {1'b0, step}) begin
                        pw_nxt    = target;
                        done_nxt  = 1'b1;
                        state_nxt = HOLD;
                    end else if (target > pulsewidth) begin
                        pw_nxt = pulsewidth + step;
                    end else begin
                        pw_nxt = pulsewidth - step;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pulsewidth <= RES'(RESET_PW);
            pwm_en     <= 1'b0;
            done       <= 1'b0;
            target     <= RES'(RESET_PW);
            step       <= RES'(1);
        end else begin
            state      <= state_nxt;
            pulsewidth <= pw_nxt;
            pwm_en     <= en_nxt;
            done       <= done_nxt;
            target     <= target_nxt;
            step       <= step_nxt;
        end
    end

endmodule
